uart_rx_frame: RTL

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame -- 8-bit UART frame receiver with start/stop checking.
//
// Frame: start(0) + 8 data bits LSB first [+ even parity] + stop(1).
// Optional feature macro: UART_RX_PARITY_EN adds the even-parity bit and
// the PE strobe. When the macro is undefined, PE is tied to 0.
//
// Parameters
//   UBRR        Clk cycles per bit period (4..65535)
// Ports
//   Clk         in   single clock, rising edge
//   Reset       in   asynchronous, active-high
//   RX          in   asynchronous serial line, idle high
//   Load        in   receive enable; dropping it aborts a frame
//   data_out    out  last good byte received
//   data_valid  out  1-cycle strobe, new byte on data_out
//   FE          out  1-cycle framing-error strobe (stop bit sampled 0)
//   PE          out  1-cycle parity-error strobe
//   busy        out  high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int unsigned UBRR = 10415
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RX,
    input  logic       Load,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       FE,
    output logic       PE,
    output logic       busy
);

    // Start bit is sampled half a bit after the edge, all later bits one
    // full bit after the previous sample point.
    localparam logic [15:0] HALF_M1 = 16'(UBRR / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(UBRR - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        dv_q, dv_d;
    logic        fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
    logic        pe_q, pe_d;
    logic        par_bad_q, par_bad_d;
`endif
    logic        tick;

    // Sample point reached for the current state.
    assign tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d      = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                // Falling edge of the synchronized line starts a frame.
                if (Load && rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = 16'd0;
                    bit_d = 3'd0;
                    state_d = rx_sync_q ? IDLE : DATA;  // high = false start
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_d     = 16'd0;
                    // Even parity: data bits plus parity bit XOR to 0.
                    par_bad_d = rx_sync_q ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                    if (!rx_sync_q) begin
                        fe_d = 1'b1;          // bad stop wins over parity
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        pe_d = 1'b1;
`endif
                    end else begin
                        dv_d   = 1'b1;
                        dout_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Losing the enable mid-frame discards everything in flight.
        if (!Load && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            dout_d  = dout_q;
            dv_d    = 1'b0;
            fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            dout_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
            pe_q      <= pe_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign FE         = fe_q;
    assign busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign PE         = pe_q;
`else
    assign PE         = 1'b0;
`endif

endmodule
